lcd_nibble_tx: RTL

- 4-bit HD44780-style LCD write transmitter: the bus-driving end of the LCD timing interface.
- Accepts one byte per valid/ready handshake and sends it as two nibbles (upper first). Generates lcd_e pulse widths, nibble gap and post-byte wait from its own internal cycle counter.
- Sits between the command/data sequencer and the LCD pins (SF_D[11:8], LCD_E, LCD_RS, LCD_RW). 50 MHz clock.

---
 rtl/lcd_nibble_tx_if.sv | 32 +++
 rtl/lcd_nibble_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx_if
// Description : Byte request handshake between the LCD command/data
//               sequencer (master) and the nibble transmitter (slave).
//                 tx_valid  master->slave  byte request
//                 tx_ready  slave->master  transmitter idle, can accept
//                 tx_data   master->slave  byte to send
//                 tx_rs     master->slave  0 = command, 1 = data
//                 tx_long   master->slave  use the long post-byte wait
//                 done      slave->master  one-cycle byte-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_nibble_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_rs;
  logic       tx_long;
  logic       done;

  modport master (
    output tx_valid, tx_data, tx_rs, tx_long,
    input  tx_ready, done
  );

  modport slave (
    input  tx_valid, tx_data, tx_rs, tx_long,
    output tx_ready, done
  );
endinterface
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx
// Description : 4-bit HD44780-style LCD write transmitter. Takes one byte per
//               valid/ready handshake and sends it as two nibbles, upper
//               first, generating setup, enable-high, hold, nibble gap and
//               post-byte wait from one internal cycle counter.
// Ports       : clk      - system clock (50 MHz)
//               reset    - synchronous active-high reset
//               bus      - slave side of lcd_nibble_tx_if (tx_valid,
//                          tx_ready, tx_data, tx_rs, tx_long, done)
//               lcd_data - SF_D[11:8] nibble
//               lcd_e    - enable strobe
//               lcd_rs   - register select
//               lcd_rw   - read/write, always 0 (write only)
// Options     : LCD_INIT_SEQ_EN - when defined, the LCD power-on nibble
//               sequence runs after reset before the first IDLE. The fixed
//               init waits (up to 750000 cycles) need CNT_W >= 20.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_tx #(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int BYTE_WAIT_CYC  = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int CNT_W          = 20
) (
  input  logic           clk,
  input  logic           reset,
  lcd_nibble_tx_if.slave bus,
  output logic [3:0]     lcd_data,
  output logic           lcd_e,
  output logic           lcd_rs,
  output logic           lcd_rw
);

  localparam logic [3:0] c_IDLE     = 4'd0;
  localparam logic [3:0] c_UP_SETUP = 4'd1;
  localparam logic [3:0] c_UP_EHIGH = 4'd2;
  localparam logic [3:0] c_UP_HOLD  = 4'd3;
  localparam logic [3:0] c_GAP      = 4'd4;
  localparam logic [3:0] c_LO_SETUP = 4'd5;
  localparam logic [3:0] c_LO_EHIGH = 4'd6;
  localparam logic [3:0] c_LO_HOLD  = 4'd7;
  localparam logic [3:0] c_WAIT     = 4'd8;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [3:0] c_INIT_WAIT = 4'd9;
  localparam logic [3:0] c_I_SETUP   = 4'd10;
  localparam logic [3:0] c_I_EHIGH   = 4'd11;
  localparam logic [3:0] c_I_HOLD    = 4'd12;
  localparam logic [3:0] c_RESET_STATE = c_INIT_WAIT;
  localparam logic       c_RESET_READY = 1'b0;
`else
  localparam logic [3:0] c_RESET_STATE = c_IDLE;
  localparam logic       c_RESET_READY = 1'b1;
`endif

  // A state of length N is left when the counter reaches N-1.
  localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_BYTE_LAST  = CNT_W'(BYTE_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

  logic [3:0]       r_state, w_state_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic [3:0]       r_lo_nibble;
  logic             r_long;
  logic [3:0]       r_lcd_data, w_lcd_data_next;
  logic             r_lcd_e, w_lcd_e_next;
  logic             r_lcd_rs, w_lcd_rs_next;
  logic             r_ready, w_ready_next;
  logic             r_done, w_done_next;
  logic             w_accept;
  logic [CNT_W-1:0] w_wait_last;

  assign w_accept    = bus.tx_valid && r_ready;
  assign w_wait_last = r_long ? c_LONG_LAST : c_BYTE_LAST;

`ifdef LCD_INIT_SEQ_EN
  // Init step k is the wait preceding nibble k; step 4 is the final wait.
  logic [2:0]       r_init_step;
  logic [CNT_W-1:0] w_init_last;

  always_comb begin
    case (r_init_step)
      3'd0:    w_init_last = CNT_W'(750000 - 1);
      3'd1:    w_init_last = CNT_W'(205000 - 1);
      3'd2:    w_init_last = CNT_W'(5000 - 1);
      default: w_init_last = CNT_W'(2000 - 1);
    endcase
  end
`endif

  // State register, counter, captured byte fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_RESET_STATE;
      r_count     <= '0;
      r_lo_nibble <= 4'd0;
      r_long      <= 1'b0;
      r_lcd_data  <= 4'd0;
      r_lcd_e     <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_ready     <= c_RESET_READY;
      r_done      <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      r_init_step <= 3'd0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_lcd_data <= w_lcd_data_next;
      r_lcd_e    <= w_lcd_e_next;
      r_lcd_rs   <= w_lcd_rs_next;
      r_ready    <= w_ready_next;
      r_done     <= w_done_next;
      if (w_accept) begin
        r_lo_nibble <= bus.tx_data[3:0];
        r_long      <= bus.tx_long;
      end
`ifdef LCD_INIT_SEQ_EN
      if (r_state == c_I_HOLD) begin
        r_init_step <= r_init_step + 3'd1;
      end
`endif
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:     if (w_accept)                  w_state_next = c_UP_SETUP;
      c_UP_SETUP: if (r_count == c_SETUP_LAST)   w_state_next = c_UP_EHIGH;
      c_UP_EHIGH: if (r_count == c_EHIGH_LAST)   w_state_next = c_UP_HOLD;
      c_UP_HOLD:                                 w_state_next = c_GAP;
      c_GAP:      if (r_count == c_GAP_LAST)     w_state_next = c_LO_SETUP;
      c_LO_SETUP: if (r_count == c_SETUP_LAST)   w_state_next = c_LO_EHIGH;
      c_LO_EHIGH: if (r_count == c_EHIGH_LAST)   w_state_next = c_LO_HOLD;
      c_LO_HOLD:                                 w_state_next = c_WAIT;
      c_WAIT:     if (r_count == w_wait_last)    w_state_next = c_IDLE;
`ifdef LCD_INIT_SEQ_EN
      c_INIT_WAIT: if (r_count == w_init_last)
                     w_state_next = (r_init_step == 3'd4) ? c_IDLE : c_I_SETUP;
      c_I_SETUP:  if (r_count == c_SETUP_LAST)   w_state_next = c_I_EHIGH;
      c_I_EHIGH:  if (r_count == c_EHIGH_LAST)   w_state_next = c_I_HOLD;
      c_I_HOLD:                                  w_state_next = c_INIT_WAIT;
`endif
      default:                                   w_state_next = c_IDLE;
    endcase
    // Counter restarts on every state entry and rests at zero in IDLE.
    if ((w_state_next != r_state) || (r_state == c_IDLE)) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + 1'b1;
    end
  end

  // Output logic: computed from the next state so that the registered pins
  // change on the same edge as the state they belong to.
  always_comb begin
    w_lcd_data_next = r_lcd_data;
    w_lcd_rs_next   = r_lcd_rs;
    w_lcd_e_next    = (w_state_next == c_UP_EHIGH) || (w_state_next == c_LO_EHIGH);
    w_ready_next    = (w_state_next == c_IDLE);
    w_done_next     = (r_state == c_WAIT) && (w_state_next == c_IDLE);
    // Data and rs only move on entry to a SETUP state, so they are stable
    // for the whole strobe and its hold cycle.
    if (w_accept) begin
      w_lcd_data_next = bus.tx_data[7:4];
      w_lcd_rs_next   = bus.tx_rs;
    end else if ((r_state == c_GAP) && (w_state_next == c_LO_SETUP)) begin
      w_lcd_data_next = r_lo_nibble;
    end
`ifdef LCD_INIT_SEQ_EN
    w_lcd_e_next = w_lcd_e_next || (w_state_next == c_I_EHIGH);
    if ((r_state == c_INIT_WAIT) && (w_state_next == c_I_SETUP)) begin
      w_lcd_data_next = (r_init_step == 3'd3) ? 4'h2 : 4'h3;
      w_lcd_rs_next   = 1'b0;
    end
`endif
  end

  assign bus.tx_ready = r_ready;
  assign bus.done     = r_done;
  assign lcd_data     = r_lcd_data;
  assign lcd_e        = r_lcd_e;
  assign lcd_rs       = r_lcd_rs;
  assign lcd_rw       = 1'b0;

endmodule
`default_nettype wire
